// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the control sequencer: opcode width, opcode values and FSM state encoding.
// State T6 only exists when MUL_DIV_EN is defined.
package cpu_defs_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b10100;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b10101;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_T0,
    ST_T1,
    ST_T1W,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
`ifdef MUL_DIV_EN
    ST_T6,
`endif
    ST_HALT
  } state_t;

  function automatic logic [OP_W-1:0] opcode_of(input logic [31:0] ir);
    return ir[31:27];
  endfunction

endpackage

// File: rtl/op_decode.sv
// Classifies a 5-bit opcode into exactly one instruction class; purely combinational.
// Without MUL_DIV_EN, mul and div fall into the illegal class.
module op_decode
  import cpu_defs_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_alu,
  output logic       is_muldiv,
  output logic       is_mfhi,
  output logic       is_mflo,
  output logic       is_nop,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    is_alu     = 1'b0;
    is_muldiv  = 1'b0;
    is_mfhi    = 1'b0;
    is_mflo    = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu = 1'b1;
`ifdef MUL_DIV_EN
      OP_MUL, OP_DIV:                is_muldiv = 1'b1;
`endif
      OP_MFHI:                       is_mfhi = 1'b1;
      OP_MFLO:                       is_mflo = 1'b1;
      OP_NOP:                        is_nop = 1'b1;
      OP_HALT:                       is_halt = 1'b1;
      default:                       is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer for a simple CPU: fetch (T0-T2, waiting on mem_ready), execute (T3-T6), halt.
// Optional mul/div support (states T5/T6 driving LOin/HIin) is enabled by defining MUL_DIV_EN.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal_op
);
  import cpu_defs_pkg::*;

  state_t          state;
  state_t          finish_state;
  logic [OP_W-1:0] opcode;
  logic            is_alu, is_muldiv, is_mfhi, is_mflo, is_nop, is_halt, is_illegal;
  logic            ir_unused;
  logic            nop_unused;

  assign opcode     = opcode_of(IR);
  assign ir_unused  = ^IR[26:0];
  assign nop_unused = is_nop;

  op_decode u_op_decode (
    .opcode     (opcode),
    .is_alu     (is_alu),
    .is_muldiv  (is_muldiv),
    .is_mfhi    (is_mfhi),
    .is_mflo    (is_mflo),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // Every instruction's last state honours stop; all other states ignore it.
  assign finish_state = stop ? ST_HALT : ST_T0;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= ST_RESET;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        ST_RESET: state <= ST_T0;
        ST_T0:    state <= ST_T1;
        ST_T1:    state <= mem_ready ? ST_T2 : ST_T1W;
        ST_T1W:   if (mem_ready) state <= ST_T2;
        ST_T2:    state <= ST_T3;
        ST_T3: begin
          if (is_illegal) illegal_op <= 1'b1;
          if (is_halt)                   state <= ST_HALT;
          else if (is_alu || is_muldiv)  state <= ST_T4;
          else                           state <= finish_state;
        end
        ST_T4:    state <= ST_T5;
`ifdef MUL_DIV_EN
        ST_T5:    state <= is_muldiv ? ST_T6 : finish_state;
        ST_T6:    state <= finish_state;
`else
        ST_T5:    state <= finish_state;
`endif
        ST_HALT:  state <= ST_HALT;
        default:  state <= ST_RESET;
      endcase
    end
  end

  // Strobes depend on the registered state; T3..T6 also look at the class of the IR loaded in T2.
  always_comb begin
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    alu_op   = '0;
`ifdef MUL_DIV_EN
    HIin     = 1'b0;
    LOin     = 1'b0;
`endif
    run      = (state != ST_RESET) && (state != ST_HALT);
    case (state)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (is_alu || is_muldiv) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (is_mfhi) begin
          Gra   = 1'b1;
          Rin   = 1'b1;
          HIout = 1'b1;
        end else if (is_mflo) begin
          Gra   = 1'b1;
          Rin   = 1'b1;
          LOout = 1'b1;
        end
      end
      ST_T4: begin
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        alu_op = opcode;
      end
      ST_T5: begin
        Zlowout = 1'b1;
`ifdef MUL_DIV_EN
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
`else
        Gra = 1'b1;
        Rin = 1'b1;
`endif
      end
`ifdef MUL_DIV_EN
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifndef MUL_DIV_EN
  assign HIin = 1'b0;
  assign LOin = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a per-instruction cycle model produces the expected strobes,
// and a negedge compare process checks every cycle against it.
`timescale 1ns/1ps
module tb_control_sequencer;

`ifdef MUL_DIV_EN
  localparam bit MDE = 1'b1;
`else
  localparam bit MDE = 1'b0;
`endif

  localparam logic [20:0] M_PCOUT    = 21'd1 << 0;
  localparam logic [20:0] M_ZHIGHOUT = 21'd1 << 1;
  localparam logic [20:0] M_ZLOWOUT  = 21'd1 << 2;
  localparam logic [20:0] M_MDROUT   = 21'd1 << 3;
  localparam logic [20:0] M_HIOUT    = 21'd1 << 4;
  localparam logic [20:0] M_LOOUT    = 21'd1 << 5;
  localparam logic [20:0] M_MARIN    = 21'd1 << 6;
  localparam logic [20:0] M_PCIN     = 21'd1 << 7;
  localparam logic [20:0] M_MDRIN    = 21'd1 << 8;
  localparam logic [20:0] M_IRIN     = 21'd1 << 9;
  localparam logic [20:0] M_YIN      = 21'd1 << 10;
  localparam logic [20:0] M_ZIN      = 21'd1 << 11;
  localparam logic [20:0] M_HIIN     = 21'd1 << 12;
  localparam logic [20:0] M_LOIN     = 21'd1 << 13;
  localparam logic [20:0] M_INCPC    = 21'd1 << 14;
  localparam logic [20:0] M_READ     = 21'd1 << 15;
  localparam logic [20:0] M_GRA      = 21'd1 << 16;
  localparam logic [20:0] M_GRB      = 21'd1 << 17;
  localparam logic [20:0] M_GRC      = 21'd1 << 18;
  localparam logic [20:0] M_RIN      = 21'd1 << 19;
  localparam logic [20:0] M_ROUT     = 21'd1 << 20;

  typedef enum {K_ALU, K_MULDIV, K_MFHI, K_MFLO, K_NOP, K_HALT, K_ILL} kind_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR = '0;
  logic        mem_ready = 1'b0;
  logic        stop = 1'b0;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, MARin, PCin, MDRin, IRin, Yin;
  logic Zin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  alu_op;
  logic        run, illegal_op;
  logic [20:0] str;

  int checks = 0;
  int errors = 0;
  int cyc_count = 0;
  int cnt_hiout = 0, cnt_rin = 0, cnt_alu = 0, cnt_pcin = 0, cnt_read = 0, cnt_loin = 0, cnt_hiin = 0;

  logic        exp_on = 1'b0;
  logic [20:0] exp_str = '0;
  logic [4:0]  exp_alu = '0;
  logic        exp_run = 1'b0;
  logic        exp_ill = 1'b0;
  logic        ill_model = 1'b0;
  string       cur_tag = "init";

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .stop(stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .run(run), .illegal_op(illegal_op)
  );

  assign str = {Rout, Rin, Grc, Grb, Gra, Read, IncPC, LOin, HIin, Zin, Yin, IRin, MDRin, PCin,
                MARin, LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  always @(negedge clock) begin
    if (exp_on) begin
      check({cur_tag, ".strobes"}, 32'(str), 32'(exp_str));
      check({cur_tag, ".alu_op"}, 32'(alu_op), 32'(exp_alu));
      check({cur_tag, ".run"}, 32'(run), 32'(exp_run));
      check({cur_tag, ".illegal_op"}, 32'(illegal_op), 32'(exp_ill));
      if (HIout) cnt_hiout++;
      if (Rin) cnt_rin++;
      if (alu_op != 5'd0) cnt_alu++;
      if (PCin) cnt_pcin++;
      if (Read) cnt_read++;
      if (LOin) cnt_loin++;
      if (HIin) cnt_hiin++;
    end
  end

  function automatic kind_t kind_of(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: return K_ALU;
      5'd15, 5'd16:           return MDE ? K_MULDIV : K_ILL;
      5'd20:                  return K_MFHI;
      5'd21:                  return K_MFLO;
      5'd26:                  return K_NOP;
      5'd27:                  return K_HALT;
      default:                return K_ILL;
    endcase
  endfunction

  task automatic rst_cnt();
    cnt_hiout = 0; cnt_rin = 0; cnt_alu = 0; cnt_pcin = 0; cnt_read = 0; cnt_loin = 0; cnt_hiin = 0;
  endtask

  // One clock cycle: drive inputs, publish the expected outputs for the state now held, advance.
  task automatic cyc(input string tag, input logic [20:0] s, input logic [4:0] a, input logic r,
                     input logic mr, input logic st);
    mem_ready = mr;
    stop      = st;
    cur_tag   = tag;
    exp_str   = s;
    exp_alu   = a;
    exp_run   = r;
    exp_ill   = ill_model;
    exp_on    = 1'b1;
    cyc_count++;
    @(posedge clock);
    #1;
  endtask

  // Fetch plus execute of one instruction; noise drives stop/mem_ready high where they must be ignored.
  task automatic instr(input string nm, input logic [31:0] ir, input int waits, input logic stop_end,
                       input logic noise, output int ncyc);
    kind_t      k;
    logic [4:0] op;
    int         start;
    op    = ir[31:27];
    k     = kind_of(op);
    start = cyc_count;
    IR    = ir;
    cyc({nm, ".T0"}, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'b1, noise, noise);
    cyc({nm, ".T1"}, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b1, waits == 0, noise);
    for (int i = 0; i < waits; i++)
      cyc({nm, ".T1W"}, M_READ | M_MDRIN, 5'd0, 1'b1, i == waits - 1, noise);
    cyc({nm, ".T2"}, M_MDROUT | M_IRIN, 5'd0, 1'b1, noise, noise);
    case (k)
      K_ALU, K_MULDIV: begin
        cyc({nm, ".T3"}, M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1, noise, noise);
        cyc({nm, ".T4"}, M_GRC | M_ROUT | M_ZIN, op, 1'b1, noise, noise);
        if (k == K_ALU) begin
          cyc({nm, ".T5"}, M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b1, noise, stop_end);
        end else begin
          cyc({nm, ".T5"}, M_ZLOWOUT | M_LOIN, 5'd0, 1'b1, noise, noise);
          cyc({nm, ".T6"}, M_ZHIGHOUT | M_HIIN, 5'd0, 1'b1, noise, stop_end);
        end
      end
      K_MFHI: cyc({nm, ".T3"}, M_GRA | M_RIN | M_HIOUT, 5'd0, 1'b1, noise, stop_end);
      K_MFLO: cyc({nm, ".T3"}, M_GRA | M_RIN | M_LOOUT, 5'd0, 1'b1, noise, stop_end);
      K_HALT: cyc({nm, ".T3"}, 21'd0, 5'd0, 1'b1, noise, noise);
      default: begin
        cyc({nm, ".T3"}, 21'd0, 5'd0, 1'b1, noise, stop_end);
        if (k == K_ILL) ill_model = 1'b1;
      end
    endcase
    ncyc = cyc_count - start;
  endtask

  task automatic halt_cycles(input string nm, input int n);
    for (int i = 0; i < n; i++)
      cyc({nm, ".HALT"}, 21'd0, 5'd0, 1'b0, i[0], ~i[0]);
  endtask

  task automatic do_clear(input string nm);
    clear = 1'b0;
    #1;
    check({nm, ".now.strobes"}, 32'(str), 32'd0);
    check({nm, ".now.alu_op"}, 32'(alu_op), 32'd0);
    check({nm, ".now.run"}, 32'(run), 32'd0);
    check({nm, ".now.illegal_op"}, 32'(illegal_op), 32'd0);
    ill_model = 1'b0;
    exp_str = '0; exp_alu = '0; exp_run = 1'b0; exp_ill = 1'b0;
    cur_tag = {nm, ".held"};
    @(posedge clock);
    #1;
    clear = 1'b1;
    cyc({nm, ".RST"}, 21'd0, 5'd0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cur=%s actual=timeout required=finish", cur_tag);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2 clear = 1'b0;
    @(posedge clock);
    #1;
    exp_on = 1'b1;
    do_clear("init");

    rst_cnt();
    instr("mfhi", 32'hA1000000, 0, 1'b0, 1'b0, n);
    check("mfhi.len", 32'(n), 32'd4);
    check("mfhi.hiout_cycles", 32'(cnt_hiout), 32'd1);
    check("mfhi.rin_cycles", 32'(cnt_rin), 32'd1);

    rst_cnt();
    instr("add_wait", 32'h18000000, 3, 1'b0, 1'b1, n);
    check("add_wait.len", 32'(n), 32'd9);
    check("add_wait.alu_cycles", 32'(cnt_alu), 32'd1);
    check("add_wait.pcin_cycles", 32'(cnt_pcin), 32'd1);
    check("add_wait.read_cycles", 32'(cnt_read), 32'd4);

    rst_cnt();
    instr("mul", 32'h78000000, 0, 1'b0, 1'b0, n);
    check("mul.len", 32'(n), MDE ? 32'd7 : 32'd4);
    check("mul.loin_cycles", 32'(cnt_loin), MDE ? 32'd1 : 32'd0);
    check("mul.hiin_cycles", 32'(cnt_hiin), MDE ? 32'd1 : 32'd0);
    check("mul.illegal_op", 32'(illegal_op), MDE ? 32'd0 : 32'd1);

    instr("mflo", 32'hA8000000, 1, 1'b0, 1'b1, n);
    instr("or", 32'h30000000, 2, 1'b0, 1'b0, n);
    instr("div", 32'h80000000, 0, 1'b0, 1'b1, n);
    instr("sub", 32'h20000000, 0, 1'b0, 1'b0, n);

    instr("add_stop", 32'h18000000, 0, 1'b1, 1'b0, n);
    halt_cycles("add_stop", 10);
    do_clear("after_halt");

    IR = 32'h18000000;
    cyc("mid.T0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("mid.T1", M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("mid.T1W", M_READ | M_MDRIN, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc("mid.T1W", M_READ | M_MDRIN, 5'd0, 1'b1, 1'b0, 1'b0);
    do_clear("mid_t1w");
    instr("and", 32'h28000000, 0, 1'b0, 1'b0, n);

    instr("undef", 32'hF8000000, 0, 1'b0, 1'b1, n);
    check("undef.len", 32'(n), 32'd4);
    instr("nop", 32'hD0000000, 0, 1'b0, 1'b0, n);
    check("nop.illegal_sticky", 32'(illegal_op), 32'd1);
    do_clear("clr_ill");

    instr("halt", 32'hD8000000, 0, 1'b0, 1'b1, n);
    halt_cycles("halt", 3);
    do_clear("final");

    exp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
